// File: rtl/ts_delay_timer.sv
// ts_delay_timer: prescaled multi-channel delay timer with one-cycle done pulses.
// Define TS_ELAPSED_EN to add per-channel elapsed-unit counters on port elapsed.
module ts_delay_timer #(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 16,
  parameter int PREC_RATIO = 1000,
  parameter int PRE_W      = 10
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS*CNT_W-1:0] delay,
  input  logic [CHANNELS-1:0]       abort,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done,
`ifdef TS_ELAPSED_EN
  output logic [CHANNELS*CNT_W-1:0] elapsed,
`endif
  output logic                      unit_tick,
  output logic                      any_busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREC_RATIO - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                tick_q, tick_d;
  logic [CHANNELS-1:0] st_q, st_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic [CNT_W-1:0]    rem_q [CHANNELS];
  logic [CNT_W-1:0]    rem_d [CHANNELS];
`ifdef TS_ELAPSED_EN
  logic [CNT_W-1:0]    ela_q [CHANNELS];
  logic [CNT_W-1:0]    ela_d [CHANNELS];
`endif

  // tick is registered so it is high while the prescaler sits at its last value
  always_comb begin
    pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
    tick_d = (pre_d == PRE_LAST);
  end

  always_comb begin
    st_d   = st_q;
    done_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rem_d[i] = rem_q[i];
`ifdef TS_ELAPSED_EN
      ela_d[i] = ela_q[i];
`endif
      case (st_q[i])
        S_IDLE: begin
          if (start[i]) begin
`ifdef TS_ELAPSED_EN
            ela_d[i] = '0;
`endif
            if (delay[i*CNT_W +: CNT_W] != '0) begin
              st_d[i]  = S_COUNT;
              rem_d[i] = delay[i*CNT_W +: CNT_W];
            end else begin
              done_d[i] = 1'b1;
            end
          end
        end
        default: begin
          // abort wins over a coincident tick; restart requests are ignored
          if (abort[i]) begin
            st_d[i]  = S_IDLE;
            rem_d[i] = '0;
          end else if (tick_q) begin
`ifdef TS_ELAPSED_EN
            ela_d[i] = ela_q[i] + ONE;
`endif
            if (rem_q[i] == ONE) begin
              st_d[i]   = S_IDLE;
              rem_d[i]  = '0;
              done_d[i] = 1'b1;
            end else begin
              rem_d[i] = rem_q[i] - ONE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      st_q   <= '0;
      done_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        rem_q[i] <= '0;
`ifdef TS_ELAPSED_EN
        ela_q[i] <= '0;
`endif
      end
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      st_q   <= st_d;
      done_q <= done_d;
      for (int i = 0; i < CHANNELS; i++) begin
        rem_q[i] <= rem_d[i];
`ifdef TS_ELAPSED_EN
        ela_q[i] <= ela_d[i];
`endif
      end
    end
  end

  assign busy      = st_q;
  assign done      = done_q;
  assign unit_tick = tick_q;
  assign any_busy  = |st_q;

`ifdef TS_ELAPSED_EN
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ela
    assign elapsed[g*CNT_W +: CNT_W] = ela_q[g];
  end
`endif

endmodule

// File: tb/tb_ts_delay_timer.sv
// Directed self-checking bench for ts_delay_timer across several prescale ratios.
// Four instances share stimulus; each test checks only the instance it targets.
module tb_ts_delay_timer;

  localparam int CH = 4;
  localparam int CW = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [CH-1:0]    start = '0;
  logic [CH-1:0]    abort = '0;
  logic [CH*CW-1:0] delay = '0;

  logic [CH-1:0] busy4, done4, busy1, done1;
  logic [CH-1:0] busy2, done2, busyk, donek;
  logic tick4, tick1, tick2, tickk;
  logic any4, any1, any2, anyk;
`ifdef TS_ELAPSED_EN
  logic [CH*CW-1:0] el4, el1, el2, elk;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int seen_done;
  int seen_busy;

  always #5 clock = ~clock;

  ts_delay_timer #(.CHANNELS(CH), .CNT_W(CW), .PREC_RATIO(4), .PRE_W(10)) u4 (
    .clock(clock), .reset(reset), .start(start), .delay(delay),
    .abort(abort), .busy(busy4), .done(done4),
`ifdef TS_ELAPSED_EN
    .elapsed(el4),
`endif
    .unit_tick(tick4), .any_busy(any4));

  ts_delay_timer #(.CHANNELS(CH), .CNT_W(CW), .PREC_RATIO(1), .PRE_W(10)) u1 (
    .clock(clock), .reset(reset), .start(start), .delay(delay),
    .abort(abort), .busy(busy1), .done(done1),
`ifdef TS_ELAPSED_EN
    .elapsed(el1),
`endif
    .unit_tick(tick1), .any_busy(any1));

  ts_delay_timer #(.CHANNELS(CH), .CNT_W(CW), .PREC_RATIO(2), .PRE_W(10)) u2 (
    .clock(clock), .reset(reset), .start(start), .delay(delay),
    .abort(abort), .busy(busy2), .done(done2),
`ifdef TS_ELAPSED_EN
    .elapsed(el2),
`endif
    .unit_tick(tick2), .any_busy(any2));

  ts_delay_timer #(.CHANNELS(CH), .CNT_W(CW), .PREC_RATIO(1000), .PRE_W(10)) uk (
    .clock(clock), .reset(reset), .start(start), .delay(delay),
    .abort(abort), .busy(busyk), .done(donek),
`ifdef TS_ELAPSED_EN
    .elapsed(elk),
`endif
    .unit_tick(tickk), .any_busy(anyk));

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = '0;
    abort = '0;
    delay = '0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  initial begin
    // reset hold and prescaler cadence, ratio 4
    repeat (3) step();
    chk("rst_busy", 64'(busy4), 64'h0);
    chk("rst_done", 64'(done4), 64'h0);
    chk("rst_tick", 64'(tick4), 64'h0);
    chk("rst_any", 64'(any4), 64'h0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("tick4_%0d", k), 64'(tick4), 64'((k % 4) == 3));
    end

    // ratio 1, ch0 delay 5
    delay[0*CW +: CW] = 16'd5;
    start = 4'b0001;
    step();
    start = '0;
    chk("r1_tick_hi", 64'(tick1), 64'h1);
    chk("r1_busy_0", 64'(busy1[0]), 64'h1);
    chk("r1_done_0", 64'(done1[0]), 64'h0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("r1_busy_%0d", k), 64'(busy1[0]), 64'h1);
      chk($sformatf("r1_done_%0d", k), 64'(done1[0]), 64'h0);
    end
    step();
    chk("r1_done_5", 64'(done1[0]), 64'h1);
    chk("r1_busy_5", 64'(busy1[0]), 64'h0);
    step();
    chk("r1_done_6", 64'(done1[0]), 64'h0);
`ifdef TS_ELAPSED_EN
    chk("r1_elapsed", 64'(el1[0*CW +: CW]), 64'd5);
`endif

    // zero delay on ch1
    delay[1*CW +: CW] = 16'd0;
    start = 4'b0010;
    step();
    start = '0;
    chk("z_done", 64'(done1[1]), 64'h1);
    chk("z_busy", 64'(busy1[1]), 64'h0);
    step();
    chk("z_done_off", 64'(done1[1]), 64'h0);
    chk("z_busy_off", 64'(busy1[1]), 64'h0);

    // abort ch2 after three counted ticks, ratio 4
    do_reset();
    delay[2*CW +: CW] = 16'd10;
    start = 4'b0100;
    step();
    start = '0;
    repeat (11) step();
    chk("ab_busy_pre", 64'(busy4[2]), 64'h1);
`ifdef TS_ELAPSED_EN
    chk("ab_el_pre", 64'(el4[2*CW +: CW]), 64'd3);
`endif
    abort = 4'b0100;
    step();
    abort = '0;
    chk("ab_busy", 64'(busy4[2]), 64'h0);
    chk("ab_done", 64'(done4[2]), 64'h0);
`ifdef TS_ELAPSED_EN
    chk("ab_elapsed", 64'(el4[2*CW +: CW]), 64'd3);
`endif
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done4[2]) seen_done++;
    end
    chk("ab_no_done", 64'(seen_done), 64'd0);

    // concurrency and ignored restart, ratio 2
    do_reset();
    delay[0*CW +: CW] = 16'd3;
    delay[3*CW +: CW] = 16'd1;
    start = 4'b1001;
    step();
    start = '0;
    chk("cc_busy_e1", 64'(busy2), 64'h9);
    chk("cc_done_e1", 64'(done2), 64'h0);
    step();
    chk("cc_done_e2", 64'(done2), 64'h8);
    chk("cc_busy_e2", 64'(busy2), 64'h1);
    chk("cc_any_e2", 64'(any2), 64'h1);
    step();
    chk("cc_done_e3", 64'(done2), 64'h0);
    delay[0*CW +: CW] = 16'd7;
    start = 4'b0001;
    step();
    start = '0;
    chk("cc_busy_e4", 64'(busy2), 64'h1);
    step();
    chk("cc_busy_e5", 64'(busy2), 64'h1);
    chk("cc_done_e5", 64'(done2), 64'h0);
    step();
    chk("cc_done_e6", 64'(done2), 64'h1);
    chk("cc_busy_e6", 64'(busy2), 64'h0);
    chk("cc_any_e6", 64'(any2), 64'h0);
`ifdef TS_ELAPSED_EN
    chk("cc_elapsed", 64'(el2[0*CW +: CW]), 64'd3);
`endif
    step();
    chk("cc_done_e7", 64'(done2), 64'h0);

    // reset mid-count, ratio 1000
    do_reset();
    delay[0*CW +: CW] = 16'd2;
    start = 4'b0001;
    step();
    start = '0;
    chk("mr_busy_start", 64'(busyk[0]), 64'h1);
    repeat (499) step();
    chk("mr_busy_500", 64'(busyk[0]), 64'h1);
    reset = 1'b1;
    #1;
    chk("mr_busy_rst", 64'(busyk[0]), 64'h0);
    chk("mr_done_rst", 64'(donek[0]), 64'h0);
    chk("mr_any_rst", 64'(anyk), 64'h0);
    repeat (2) step();
    reset = 1'b0;
    seen_done = 0;
    seen_busy = 0;
    for (int k = 0; k < 3000; k++) begin
      step();
      if (donek[0]) seen_done++;
      if (busyk[0]) seen_busy++;
    end
    chk("mr_no_done", 64'(seen_done), 64'd0);
    chk("mr_no_busy", 64'(seen_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
